uart_msg_arbiter: RTL

//  Shares one UART transmitter and one synchronous message ROM between NUM_REQ requesters.

---
 rtl/uart_msg_arbiter_if.sv | 33 +++
 rtl/uart_msg_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/uart_msg_arbiter_if.sv
// Requester/ROM/UART bundle around uart_msg_arbiter.
// abort/aborted exist only when UART_ARB_ABORT_EN is defined.
interface uart_msg_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8
);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] base_addr;
    logic [ADDR_WIDTH-1:0]         rom_addr;
    logic [7:0]                    rom_data;
    logic                          tx_full;
    logic                          wr;
    logic [7:0]                    w_data;
    logic                          busy;
    logic [GW-1:0]                 grant_id;
    logic                          done;
`ifdef UART_ARB_ABORT_EN
    logic                          abort;
    logic                          aborted;

    modport master (output req, base_addr, rom_data, tx_full, abort,
                    input  rom_addr, wr, w_data, busy, grant_id, done, aborted);
    modport slave  (input  req, base_addr, rom_data, tx_full, abort,
                    output rom_addr, wr, w_data, busy, grant_id, done, aborted);
`else
    modport master (output req, base_addr, rom_data, tx_full,
                    input  rom_addr, wr, w_data, busy, grant_id, done);
    modport slave  (input  req, base_addr, rom_data, tx_full,
                    output rom_addr, wr, w_data, busy, grant_id, done);
`endif
endinterface

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter streaming zero-terminated ROM messages into a UART TX port.
// Define UART_ARB_ABORT_EN to add the abort/aborted handshake.
module uart_msg_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LEN    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    uart_msg_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {IDLE, FETCH, DATA, SEND, DONE} state_t;

    state_t                state, state_nxt;
    logic [NUM_REQ-1:0]    pending, grant_mask;
    logic [GW-1:0]         rr_ptr, winner, grant_id;
    logic [GW:0]           cand;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [7:0]            w_data;
    logic [CW-1:0]         byte_cnt;
    logic                  grant, term, wr, abort_hit;

`ifdef UART_ARB_ABORT_EN
    logic aborted;

    assign abort_hit   = bus.abort && (state == FETCH || state == DATA || state == SEND);
    assign bus.aborted = aborted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) aborted <= 1'b0;
        else          aborted <= abort_hit;
    end
`else
    assign abort_hit = 1'b0;
`endif

    // Scan downwards so the lowest offset from rr_ptr wins.
    always_comb begin
        winner = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
            if (pending[cand[GW-1:0]]) winner = cand[GW-1:0];
        end
    end

    assign grant      = (state == IDLE) && (|pending);
    assign grant_mask = grant ? (NUM_REQ'(1) << winner) : '0;
    assign term       = (bus.rom_data == 8'h00) || (byte_cnt == CW'(MAX_LEN));

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        case (state)
            IDLE:    if (|pending) state_nxt = FETCH;
            FETCH:   state_nxt = DATA;
            DATA:    state_nxt = term ? DONE : SEND;
            SEND:    if (!bus.tx_full) begin
                         wr        = 1'b1;
                         state_nxt = FETCH;
                     end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            wr        = 1'b0;
            state_nxt = DONE;
        end
    end

    // A req coinciding with its own grant re-queues the message.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending <= '0;
        else          pending <= (pending & ~grant_mask) | bus.req;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            rom_addr <= '0;
            w_data   <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                grant_id <= winner;
                rom_addr <= bus.base_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
                byte_cnt <= '0;
            end
            if (state == DATA && state_nxt == SEND) w_data <= bus.rom_data;
            if (wr) begin
                rom_addr <= rom_addr + 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == DONE)
                rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.w_data   = w_data;
    assign bus.wr       = wr;
    assign bus.busy     = (state != IDLE);
    assign bus.grant_id = grant_id;
    assign bus.done     = (state == DONE);
endmodule
